// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with registered grant index and optional hold limit
module rr_arbiter_8 #(
    parameter int HOLD_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic       grant_valid,
    output logic [2:0] grant_idx
);
    localparam int HW = ($clog2(HOLD_LIMIT + 1) > 1) ? $clog2(HOLD_LIMIT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_idx_q, grant_idx_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    elig;
    logic [2:0]    sel;
    logic          grant;
    logic          timeout;

    // first set bit of e scanning upward from p, wrapping 7 -> 0
    function automatic logic [2:0] rr_pick(input logic [7:0] e, input logic [2:0] p);
        logic [2:0] k;
        logic [2:0] s;
        s = p;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (e[k]) s = k;
        end
        return s;
    endfunction

    assign timeout     = (HOLD_LIMIT != 0) && (hold_cnt_q == HW'(HOLD_LIMIT));
    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = grant_idx_q;

    // next-state: keep, release, or rotate on timeout; the grant action overrides all
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        elig        = req;
        grant       = 1'b0;
        if (state_q == IDLE) begin
            grant = |req;
        end else if (!req[grant_idx_q]) begin
            grant = |req;
            if (!grant) state_d = IDLE;
        end else if (timeout) begin
            elig       = req & ~(8'b1 << grant_idx_q);
            grant      = |elig;
            hold_cnt_d = HW'(1);
        end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
        sel = rr_pick(elig, ptr_q);
        if (grant) begin
            state_d     = BUSY;
            grant_idx_d = sel;
            ptr_d       = sel + 3'd1;
            hold_cnt_d  = HW'(1);
        end
    end

    // state registers, cleared immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_idx_q <= 3'd0;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end
endmodule
